// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//   Bundle between the control sequencer and the datapath it steers.
//
//   run             level, high permits fetch/execute cycles
//   mem_rdy         memory read complete (sampled by the sequencer in T1)
//   ir              datapath IR contents: opcode [31:27], Ra [26:23],
//                   Rb [22:19], Rc [18:15]
//   enable          one-hot register load vector
//                   (0-15 R0-R15, 20 PC, 21 MDR, 23 IR, 24 Z, 25 MAR, 27 Y)
//   busSelect       one-hot bus driver select
//                   (0-15 R0-R15, 19 Zlow, 20 PC, 21 MDR)
//   MR_Read         memory-to-MDR read strobe
//   IncPC           PC increment request
//   Control_Signals ALU operation code
//
//   master : the sequencer (drives the control vectors)
//   slave  : the datapath / environment (drives run, mem_rdy, ir)
// -----------------------------------------------------------------------------
interface control_sequencer_if;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic        MR_Read;
  logic        IncPC;
  logic [3:0]  Control_Signals;

  modport master (
    input  run, mem_rdy, ir,
    output enable, busSelect, MR_Read, IncPC, Control_Signals
  );

  modport slave (
    output run, mem_rdy, ir,
    input  enable, busSelect, MR_Read, IncPC, Control_Signals
  );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Moore-style fetch/execute sequencer for a simple register datapath.
//   Each instruction walks T0 (MAR<-PC, PC++), T1 (MDR<-mem, waits on mem_rdy),
//   T2 (IR<-MDR), T3 (Y<-Rb, decode), T4 (Z<-Y op Rc), T5 (Ra<-Zlow, retire).
//   Opcode 5'h1F parks in HALT; opcodes 12..30 park in FAULT with a sticky flag.
//   Both park states are left only through clr.
//
//   clk          system clock, all state on the rising edge
//   clr          synchronous active-high reset, wins over everything
//   bus          control_sequencer_if.master (run/mem_rdy/ir in, controls out)
//   state        present state code
//   done         one-cycle pulse in T5 for each retired instruction
//   fault        sticky illegal-opcode flag
//   instr_count  retired-instruction counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic                       clk,
  input  logic                       clr,
  control_sequencer_if.master        bus,
  output logic [3:0]                 state,
  output logic                       done,
  output logic                       fault,
  output logic [15:0]                instr_count
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd7,
    S_T1    = 4'd8,
    S_T2    = 4'd9,
    S_T3    = 4'd10,
    S_T4    = 4'd11,
    S_T5    = 4'd12,
    S_HALT  = 4'd13,
    S_FAULT = 4'd14
  } state_e;

  // Register-file and datapath bit positions in the enable/busSelect vectors.
  localparam int unsigned BIT_ZLOW = 19;
  localparam int unsigned BIT_PC   = 20;
  localparam int unsigned BIT_MDR  = 21;
  localparam int unsigned BIT_IR   = 23;
  localparam int unsigned BIT_Z    = 24;
  localparam int unsigned BIT_MAR  = 25;
  localparam int unsigned BIT_Y    = 27;

  state_e      state_q, state_d;
  logic [4:0]  opcode_q;
  logic [3:0]  ra_q, rb_q, rc_q;
  logic        fault_q;
  logic [15:0] count_q;

  // Live decode of the IR, only meaningful while in T3.
  logic [4:0]  ir_opcode;
  logic        op_legal;
  logic        op_halt;

  assign ir_opcode = bus.ir[31:27];
  assign op_legal  = (ir_opcode <= 5'd11);
  assign op_halt   = (ir_opcode == 5'h1F);

  // ---------------------------------------------------------------------------
  // State and latched fields
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;

      // Fields are captured as T3 is left; T4/T5 then ignore later IR changes.
      if (state_q == S_T3) begin
        opcode_q <= ir_opcode;
        ra_q     <= bus.ir[26:23];
        rb_q     <= bus.ir[22:19];
        rc_q     <= bus.ir[18:15];
        if (!op_legal && !op_halt) begin
          fault_q <= 1'b1;
        end
      end

      if (state_q == S_T5) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (bus.mem_rdy) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (op_legal)     state_d = S_T4;
        else if (op_halt) state_d = S_HALT;
        else              state_d = S_FAULT;
      end
      S_T4:    state_d = S_T5;
      // run only matters at instruction boundaries; a drop mid-instruction
      // still lets the current one retire.
      S_T5:    state_d = bus.run ? S_T0 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  logic [31:0] enable_c;
  logic [31:0] bus_sel_c;
  logic        mr_read_c;
  logic        inc_pc_c;
  logic [3:0]  alu_op_c;
  logic        done_c;

  always_comb begin
    enable_c  = '0;
    bus_sel_c = '0;
    mr_read_c = 1'b0;
    inc_pc_c  = 1'b0;
    alu_op_c  = '0;
    done_c    = 1'b0;
    case (state_q)
      S_T0: begin
        bus_sel_c[BIT_PC]  = 1'b1;
        enable_c[BIT_MAR]  = 1'b1;
        enable_c[BIT_PC]   = 1'b1;
        inc_pc_c           = 1'b1;
      end
      S_T1: begin
        mr_read_c          = 1'b1;
        enable_c[BIT_MDR]  = 1'b1;
      end
      S_T2: begin
        bus_sel_c[BIT_MDR] = 1'b1;
        enable_c[BIT_IR]   = 1'b1;
      end
      S_T3: begin
        // Rb has not been latched yet, so it comes straight from the IR.
        bus_sel_c          = 32'd1 << bus.ir[22:19];
        enable_c[BIT_Y]    = 1'b1;
      end
      S_T4: begin
        bus_sel_c          = 32'd1 << rc_q;
        enable_c[BIT_Z]    = 1'b1;
        alu_op_c           = opcode_q[3:0];
      end
      S_T5: begin
        bus_sel_c[BIT_ZLOW] = 1'b1;
        enable_c            = 32'd1 << ra_q;
        done_c              = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.enable          = enable_c;
  assign bus.busSelect       = bus_sel_c;
  assign bus.MR_Read         = mr_read_c;
  assign bus.IncPC           = inc_pc_c;
  assign bus.Control_Signals = alu_op_c;

  assign state       = state_q;
  assign done        = done_c;
  assign fault       = fault_q;
  assign instr_count = count_q;

  // The low IR bits carry immediates consumed elsewhere in the datapath; the
  // latched Rb and opcode MSB are kept only for debug visibility.
  logic ir_unused;
  assign ir_unused = ^{bus.ir[14:0], rb_q, opcode_q[4]};

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer. Each stimulus cycle pushes the
//   outputs that the state table predicts for that cycle; a single compare
//   process checks every field on the falling edge. A few literal checks pin
//   the expected values of the reference instruction.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  state;
  logic        done;
  logic        fault;
  logic [15:0] instr_count;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus.master),
    .state       (state),
    .done        (done),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [31:0] en;
    logic [31:0] bs;
    logic        mr;
    logic        inc;
    logic [3:0]  cs;
    logic        dn;
    logic        flt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   tests = 0;
  int   fails = 0;

  // Model state: what the bench believes has been latched / counted so far.
  logic [31:0] lat_ir  = '0;
  logic        m_fault = 1'b0;
  logic [15:0] m_count = '0;

  localparam logic [31:0] NOISE = 32'h7C3E_1F0F;
  localparam logic [31:0] IR_A  = 32'h389A_8000;  // op 7, Ra 1, Rb 3, Rc 5

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h1234};
  endfunction

  // Output table: which control bits each state code raises.
  function automatic exp_t outs(input int st, input logic [31:0] live);
    exp_t e;
    e = '{st: 4'(st), en: '0, bs: '0, mr: 1'b0, inc: 1'b0, cs: '0,
          dn: 1'b0, flt: m_fault, cnt: m_count};
    case (st)
      7:  begin e.bs[20] = 1'b1; e.en[25] = 1'b1; e.en[20] = 1'b1; e.inc = 1'b1; end
      8:  begin e.mr = 1'b1; e.en[21] = 1'b1; end
      9:  begin e.bs[21] = 1'b1; e.en[23] = 1'b1; end
      10: begin e.bs[live[22:19]] = 1'b1; e.en[27] = 1'b1; end
      11: begin e.bs[lat_ir[18:15]] = 1'b1; e.en[24] = 1'b1; e.cs = lat_ir[30:27]; end
      12: begin e.bs[19] = 1'b1; e.en[lat_ir[26:23]] = 1'b1; e.dn = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, record the expectation for this cycle,
  // then step to just after the next rising edge.
  task automatic tick(input logic c, input logic r, input logic m,
                      input logic [31:0] i, input int st, input bit chk);
    clr         = c;
    bus.run     = r;
    bus.mem_rdy = m;
    bus.ir      = i;
    if (chk) exp_q.push_back(outs(st, i));
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    lat_ir  = '0;
    m_fault = 1'b0;
    m_count = '0;
  endtask

  // One instruction starting in T0; the caller has already moved out of IDLE.
  task automatic instr(input logic [31:0] i, input int waits,
                       input logic run_mid, input logic run_after);
    tick(1'b0, run_mid, 1'b1, NOISE, 7, 1'b1);
    for (int w = 0; w < waits; w++) tick(1'b0, run_mid, 1'b0, NOISE, 8, 1'b1);
    tick(1'b0, run_mid, 1'b1, NOISE, 8, 1'b1);
    tick(1'b0, run_mid, 1'b1, NOISE, 9, 1'b1);
    tick(1'b0, run_mid, 1'b1, i, 10, 1'b1);
    lat_ir = i;
    if (i[31:27] <= 5'd11) begin
      tick(1'b0, run_mid, 1'b1, NOISE, 11, 1'b1);
      tick(1'b0, run_after, 1'b1, NOISE, 12, 1'b1);
      m_count = m_count + 16'd1;
    end else if (i[31:27] != 5'h1F) begin
      m_fault = 1'b1;
    end
  endtask

  // Compare process: every queued cycle, every output field.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      check("state",           32'(state),               32'(cur_e.st));
      check("enable",          bus.enable,               cur_e.en);
      check("busSelect",       bus.busSelect,            cur_e.bs);
      check("MR_Read",         32'(bus.MR_Read),         32'(cur_e.mr));
      check("IncPC",           32'(bus.IncPC),           32'(cur_e.inc));
      check("Control_Signals", 32'(bus.Control_Signals), 32'(cur_e.cs));
      check("done",            32'(done),                32'(cur_e.dn));
      check("fault",           32'(fault),               32'(cur_e.flt));
      check("instr_count",     32'(instr_count),         32'(cur_e.cnt));
    end
  end

  initial begin
    clr = 1'b1; bus.run = 1'b0; bus.mem_rdy = 1'b0; bus.ir = '0;

    // Reset, then idle with run low.
    tick(1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, NOISE, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);
    check("pin_idle_state", 32'(state), 32'd0);

    // Reference instruction, minimum latency, run dropped at T5 -> IDLE.
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 7, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 8, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 9, 1'b1);
    tick(1'b0, 1'b1, 1'b1, IR_A, 10, 1'b1);
    lat_ir = IR_A;
    check("pin_t4_busSelect", bus.busSelect, 32'h0000_0020);
    check("pin_t4_alu_op", 32'(bus.Control_Signals), 32'd7);
    tick(1'b0, 1'b1, 1'b1, NOISE, 11, 1'b1);
    check("pin_t5_enable", bus.enable, 32'h0000_0002);
    check("pin_t5_done", 32'(done), 32'd1);
    tick(1'b0, 1'b0, 1'b1, NOISE, 12, 1'b1);
    m_count = m_count + 16'd1;
    check("pin_count_after_one", 32'(instr_count), 32'd1);
    check("pin_idle_after_t5", 32'(state), 32'd0);
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);

    // Three T1 waits, opcode 11 boundary, back-to-back into an instruction
    // that has run dropped from T0 on and writes R0.
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    instr(mk(5'd11, 4'd15, 4'd0, 4'd9), 3, 1'b1, 1'b1);
    instr(mk(5'd0, 4'd0, 4'd15, 4'd0), 1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);
    check("pin_count_after_three", 32'(instr_count), 32'd3);

    // HALT: held against run toggling, left only through clr.
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    instr(mk(5'h1F, 4'd2, 4'd3, 4'd4), 0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b0, k[0], 1'b1, NOISE, 13, 1'b1);
    check("pin_halt_state", 32'(state), 32'd13);
    tick(1'b1, 1'b1, 1'b1, NOISE, 13, 1'b1);
    model_clear();
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);

    // FAULT on opcode 5'h0F and on the first illegal opcode 12.
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    instr(mk(5'h0F, 4'd6, 4'd7, 4'd8), 0, 1'b1, 1'b1);
    check("pin_fault_set", 32'(fault), 32'd1);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1, NOISE, 14, 1'b1);
    tick(1'b1, 1'b1, 1'b1, NOISE, 14, 1'b1);
    model_clear();
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);
    check("pin_fault_cleared", 32'(fault), 32'd0);
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    instr(mk(5'd12, 4'd1, 4'd2, 4'd3), 0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 14, 1'b1);
    tick(1'b1, 1'b0, 1'b1, NOISE, 14, 1'b1);
    model_clear();

    // clr in T4 aborts and clears the counter; clr in a T1 wait beats run.
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    instr(IR_A, 0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 7, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 8, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 9, 1'b1);
    tick(1'b0, 1'b1, 1'b1, IR_A, 10, 1'b1);
    lat_ir = IR_A;
    tick(1'b1, 1'b1, 1'b1, NOISE, 11, 1'b1);
    model_clear();
    check("pin_abort_state", 32'(state), 32'd0);
    check("pin_abort_count", 32'(instr_count), 32'd0);
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, NOISE, 7, 1'b1);
    tick(1'b0, 1'b1, 1'b0, NOISE, 8, 1'b1);
    tick(1'b1, 1'b1, 1'b1, NOISE, 8, 1'b1);
    model_clear();
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);

    // Counter wrap: preload 16'hFFFF, one instruction retires to 16'h0000.
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_count = 16'hFFFF;
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, NOISE, 0, 1'b1);
    instr(mk(5'd3, 4'd12, 4'd5, 4'd6), 0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, NOISE, 0, 1'b1);
    check("pin_count_wrap", 32'(instr_count), 32'd0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
